// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants used by the pipeline write-back and ID stages.
package regfile_pkg;
  localparam int REG_NUM = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE = 1'b1;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
endpackage

// File: rtl/regfile_rport.sv
// regfile_rport: combinational read-port mux (reset, enable, $0, write-first bypass, array).
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                  rst,
  input  logic                  re,
  input  logic [REG_ADDR_W-1:0] raddr,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W-1:0]     arr_data,
  output logic [DATA_W-1:0]     rdata
);
  // $0 is checked before the bypass so a discarded write to $0 never leaks out
  assign rdata = (rst == RST_ENABLE || re != READ_ENABLE || raddr == '0) ? '0 :
                 (we == WRITE_ENABLE && waddr == raddr) ? wdata : arr_data;
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 register file, one synchronous write port, two combinational read ports.
module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM = regfile_pkg::REG_NUM,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re1,
  input  logic [REG_ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0]     rdata1,
  input  logic                  re2,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata2
);
  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic [DATA_W-1:0] arr1, arr2;
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) regs_q <= '{default: '0};
    else if (we == WRITE_ENABLE && waddr != '0) regs_q[waddr] <= wdata;
  end
  assign arr1 = regs_q[raddr1];
  assign arr2 = regs_q[raddr2];
  regfile_rport #(.REG_ADDR_W(REG_ADDR_W), .DATA_W(DATA_W)) u_rport1 (
    .rst(rst), .re(re1), .raddr(raddr1), .we(we), .waddr(waddr), .wdata(wdata),
    .arr_data(arr1), .rdata(rdata1)
  );
  regfile_rport #(.REG_ADDR_W(REG_ADDR_W), .DATA_W(DATA_W)) u_rport2 (
    .rst(rst), .re(re2), .raddr(raddr2), .we(we), .waddr(waddr), .wdata(wdata),
    .arr_data(arr2), .rdata(rdata2)
  );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and randomized checks of regfile against an array-based reference model.
module tb_regfile;
  logic clk = 0, rst = 1, we = 0, re1 = 0, re2 = 0;
  logic [4:0] waddr = 0, raddr1 = 0, raddr2 = 0;
  logic [31:0] wdata = 0, rdata1, rdata2;
  logic [31:0] model [32];
  int checks = 0, failures = 0;

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] ra);
    if (rst || !re || ra == 0) return 0;
    if (we && waddr == ra) return wdata;
    return model[ra];
  endfunction

  task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    rst = r; we = w; waddr = wa; wdata = wd; re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) for (int i = 0; i < 32; i++) model[i] = 0;
    else if (we && waddr != 0) model[waddr] = wdata;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    for (int i = 0; i < 32; i++) model[i] = 0;
    drive(1, 0, 0, 0, 1, 5, 1, 9);
    checks++; if (rdata1 !== 0 || rdata2 !== 0) begin failures++; $display("FAIL reset_pre_clk rdata1=%h rdata2=%h exp 0", rdata1, rdata2); end
    tick();
    drive(0, 1, 5, 32'hDEADBEEF, 1, 5, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 5, 0, 0);
    checks++; if (rdata1 !== 32'hDEADBEEF) begin failures++; $display("FAIL reset_prewrite got %h exp deadbeef", rdata1); end
    drive(1, 0, 0, 0, 1, 5, 0, 0);
    checks++; if (rdata1 !== 0) begin failures++; $display("FAIL reset_during got %h exp 0", rdata1); end
    tick();
    drive(0, 0, 0, 0, 1, 5, 0, 0);
    checks++; if (rdata1 !== 0) begin failures++; $display("FAIL reset_after got %h exp 0", rdata1); end
    drive(1, 1, 7, 32'h11, 1, 7, 1, 7);
    checks++; if (rdata1 !== 0 || rdata2 !== 0) begin failures++; $display("FAIL reset_write_cycle rdata1=%h rdata2=%h exp 0", rdata1, rdata2); end
    tick();
    drive(0, 0, 0, 0, 1, 7, 0, 0);
    e = exp_read(1, 7);
    checks++; if (rdata1 !== e || rdata1 !== 0) begin failures++; $display("FAIL reset_write_dropped got %h exp %h", rdata1, e); end
  endtask

  task automatic test_basic();
    drive(0, 1, 1, 32'h11, 0, 0, 0, 0); tick();
    drive(0, 1, 31, 32'hFFFFFFFF, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 1, 1, 31);
    checks++; if (rdata1 !== 32'h11) begin failures++; $display("FAIL basic_r1 got %h exp 00000011", rdata1); end
    checks++; if (rdata2 !== 32'hFFFFFFFF) begin failures++; $display("FAIL basic_r31 got %h exp ffffffff", rdata2); end
  endtask

  task automatic test_zero();
    drive(0, 1, 0, 32'h12345678, 1, 0, 1, 0);
    checks++; if (rdata1 !== 0 || rdata2 !== 0) begin failures++; $display("FAIL zero_same_cycle rdata1=%h rdata2=%h exp 0", rdata1, rdata2); end
    tick();
    drive(0, 0, 0, 0, 1, 0, 1, 0);
    checks++; if (rdata1 !== 0) begin failures++; $display("FAIL zero_next_cycle got %h exp 0", rdata1); end
  endtask

  task automatic test_bypass();
    drive(0, 1, 3, 32'hAAAA0000, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 3, 1, 3);
    checks++; if (rdata1 !== 32'hAAAA0000) begin failures++; $display("FAIL bypass_old got %h exp aaaa0000", rdata1); end
    drive(0, 1, 3, 32'h5555FFFF, 1, 3, 1, 3);
    checks++; if (rdata1 !== 32'h5555FFFF) begin failures++; $display("FAIL bypass_port1 got %h exp 5555ffff", rdata1); end
    checks++; if (rdata2 !== 32'h5555FFFF) begin failures++; $display("FAIL bypass_port2 got %h exp 5555ffff", rdata2); end
    tick();
    drive(0, 0, 0, 0, 1, 3, 1, 3);
    checks++; if (rdata1 !== 32'h5555FFFF || rdata2 !== 32'h5555FFFF) begin failures++; $display("FAIL bypass_retained rdata1=%h rdata2=%h exp 5555ffff", rdata1, rdata2); end
  endtask

  task automatic test_re_gating();
    drive(0, 1, 9, 32'hCAFEBABE, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 9, 1, 9);
    checks++; if (rdata1 !== 0) begin failures++; $display("FAIL re_gate_port1 got %h exp 0", rdata1); end
    checks++; if (rdata2 !== 32'hCAFEBABE) begin failures++; $display("FAIL re_gate_port2 got %h exp cafebabe", rdata2); end
    drive(0, 1, 9, 32'h1, 0, 9, 0, 9);
    checks++; if (rdata1 !== 0 || rdata2 !== 0) begin failures++; $display("FAIL re_gate_bypass rdata1=%h rdata2=%h exp 0", rdata1, rdata2); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int v = 1; v <= 3; v++) begin
      drive(0, 1, 4, 32'(v), 1, 4, 0, 0);
      checks++; if (rdata1 !== 32'(v)) begin failures++; $display("FAIL chain_step%0d got %h exp %h", v, rdata1, 32'(v)); end
      tick();
    end
    drive(0, 0, 0, 0, 1, 4, 0, 0);
    checks++; if (rdata1 !== 3) begin failures++; $display("FAIL chain_final got %h exp 3", rdata1); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    logic [4:0] wa;
    for (int n = 0; n < 400; n++) begin
      wa = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
            $urandom_range(0, 7) != 0, ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            $urandom_range(0, 7) != 0, ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
      e1 = exp_read(re1, raddr1);
      e2 = exp_read(re2, raddr2);
      checks++; if (rdata1 !== e1) begin failures++; $display("FAIL rand_port1 n=%0d ra=%0d got %h exp %h", n, raddr1, rdata1, e1); end
      checks++; if (rdata2 !== e2) begin failures++; $display("FAIL rand_port2 n=%0d ra=%0d got %h exp %h", n, raddr2, rdata2, e2); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_re_gating();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
